// File: rtl/uart_tx.sv
// UART transmitter. Serialises each accepted word as an LSB-first asynchronous
// frame: start bit, data bits, optional parity bit, then one or two stop bits.
// Each bit period is exactly clks_per_bit = system_clock/tx_baudrate cycles.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset (aborts any frame, line idles high)
//   tx_data  word to send, latched when tx_valid && tx_ready at a rising edge
//   tx_valid producer has a word
//   tx_ready transmitter can accept a word (registered)
//   tx       serial line, idle high (registered)
//   tx_busy  frame in progress (registered)
//   tx_done  one-cycle pulse on the edge the frame completes (registered)
module uart_tx #(
  parameter int system_clock = 25000000,
  parameter int tx_baudrate  = 9600,
  parameter int data_width   = 8,
  parameter int parity_mode  = 0,
  parameter int stop_bits    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [data_width-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CPB = system_clock / tx_baudrate;
  localparam int CW  = $clog2(CPB);

  // parity_mode 3 and stop_bits other than 2 fall back to none / 1.
  localparam bit PAR_EN  = (parity_mode == 1) || (parity_mode == 2);
  localparam bit PAR_ODD = (parity_mode == 2);
  localparam int NSTOP   = (stop_bits == 2) ? 2 : 1;

  generate
    if (CPB < 2) begin : g_bad_cpb
      $error("uart_tx: system_clock/tx_baudrate must be >= 2");
    end
  endgenerate

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [data_width-1:0] sh;
  logic                  par;
  logic [3:0]            idx;   // data bit index, reused as stop bit index
  logic                  bit_end;

  // Last cycle of the current bit period; the next bit is launched on this edge.
  assign bit_end = (cnt == CW'(CPB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      sh       <= '0;
      par      <= 1'b0;
      idx      <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state != S_IDLE)
        cnt <= bit_end ? '0 : cnt + 1'b1;
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          // ready is held low out of reset and rises one edge later, so the
          // first accept can only happen on the following edge.
          if (!tx_ready) begin
            tx_ready <= 1'b1;
          end else if (tx_valid) begin
            sh       <= tx_data;
            par      <= (^tx_data) ^ PAR_ODD;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
            tx       <= 1'b0;
            cnt      <= '0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx    <= sh[0];
            sh    <= sh >> 1;
            idx   <= '0;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (idx == 4'(data_width - 1)) begin
              if (PAR_EN) begin
                tx    <= par;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                idx   <= '0;
                state <= S_STOP;
              end
            end else begin
              tx  <= sh[0];
              sh  <= sh >> 1;
              idx <= idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            idx   <= '0;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (idx == 4'(NSTOP - 1)) begin
              state    <= S_IDLE;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
              tx_done  <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8N1, 8E2, 8O2) at 10 clocks per bit,
// driven in lock-step and compared every cycle against a frame-level model.
module tb_uart_tx;

  localparam int CPB = 10;
  localparam int NCFG = 3;
  localparam int PM [NCFG]   = '{0, 1, 2};
  localparam int SB [NCFG]   = '{1, 2, 2};
  localparam int NLIT [NCFG] = '{100, 120, 120};

  logic                      clk;
  logic                      rst_n;
  logic [NCFG-1:0][7:0]      tx_data;
  logic [NCFG-1:0]           tx_valid;
  logic [NCFG-1:0]           tx_ready;
  logic [NCFG-1:0]           tx;
  logic [NCFG-1:0]           tx_busy;
  logic [NCFG-1:0]           tx_done;

  genvar g;
  generate
    for (g = 0; g < NCFG; g++) begin : g_dut
      uart_tx #(
        .system_clock(1000000),
        .tx_baudrate (100000),
        .data_width  (8),
        .parity_mode (PM[g]),
        .stop_bits   (SB[g])
      ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_data (tx_data[g]),
        .tx_valid(tx_valid[g]),
        .tx_ready(tx_ready[g]),
        .tx      (tx[g]),
        .tx_busy (tx_busy[g]),
        .tx_done (tx_done[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Frame as bit list, index 0 = first bit on the line; unused upper bits are 1.
  function automatic logic [11:0] mk_frame(input logic [7:0] d, input int pm, input int sb);
    logic [11:0] f;
    int n;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    n = 9;
    if (pm == 1 || pm == 2) begin
      f[n] = (^d) ^ (pm == 2);
      n++;
    end
    for (int i = 0; i < sb; i++) f[n+i] = 1'b1;
    return f;
  endfunction

  function automatic int frame_len(input int k);
    return (1 + 8 + ((PM[k] != 0) ? 1 : 0) + SB[k]) * CPB;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s cfg%0d cyc%0d: got %0h expected %0h", nm, k, cyc, act, exp_v);
    end
  endtask

  // Model state: position within the current frame, counted in clocks.
  logic        busy_m  [NCFG];
  logic        ready_m [NCFG];
  logic        done_m  [NCFG];
  int          pos     [NCFG];
  logic [11:0] frame_m [NCFG];
  logic        prev_rdy[NCFG];
  int          fall_cyc[NCFG];

  initial begin
    logic [11:0] f;
    logic        exp_tx;
    for (int k = 0; k < NCFG; k++) begin
      busy_m[k] = 0; ready_m[k] = 0; done_m[k] = 0; pos[k] = 0;
      frame_m[k] = '1; prev_rdy[k] = 0; fall_cyc[k] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        f = mk_frame(8'hA5, 0, 1);
        chk("frame_a5_8n1", 0, 32'(f[9:0]), 32'(10'b1101001010));
        f = mk_frame(8'h07, 1, 2);
        chk("parity_even_07", 1, 32'(f[9]), 32'd1);
        f = mk_frame(8'h07, 2, 2);
        chk("parity_odd_07", 2, 32'(f[9]), 32'd0);
      end
      for (int k = 0; k < NCFG; k++) begin
        if (!rst_n) begin
          busy_m[k] = 0; ready_m[k] = 0; done_m[k] = 0; pos[k] = 0;
        end
        exp_tx = busy_m[k] ? frame_m[k][pos[k] / CPB] : 1'b1;
        chk("tx",       k, 32'(tx[k]),       32'(exp_tx));
        chk("tx_ready", k, 32'(tx_ready[k]), 32'(ready_m[k]));
        chk("tx_busy",  k, 32'(tx_busy[k]),  32'(busy_m[k]));
        chk("tx_done",  k, 32'(tx_done[k]),  32'(done_m[k]));
        // Absolute frame length pinned against the literal cycle count.
        if (rst_n && prev_rdy[k] && !tx_ready[k]) fall_cyc[k] = cyc;
        if (tx_done[k]) chk("frame_cycles", k, 32'(cyc - fall_cyc[k]), 32'(NLIT[k]));
        prev_rdy[k] = tx_ready[k];
        // Advance the model to the state after the coming rising edge.
        if (rst_n) begin
          done_m[k] = 0;
          if (busy_m[k]) begin
            pos[k]++;
            if (pos[k] == frame_len(k)) begin
              busy_m[k] = 0; ready_m[k] = 1; done_m[k] = 1;
            end
          end else if (!ready_m[k]) begin
            ready_m[k] = 1;
          end else if (tx_valid[k]) begin
            frame_m[k] = mk_frame(tx_data[k], PM[k], SB[k]);
            busy_m[k] = 1; ready_m[k] = 0; pos[k] = 0;
          end
        end
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_valid = '1;
    tx_data[0] = 8'hA5; tx_data[1] = 8'h07; tx_data[2] = 8'h07;
    cyc_wait(5);
    rst_n = 1'b1;
    // Frame in flight: changing the data must not affect it.
    cyc_wait(20);
    tx_valid = '0;
    tx_data  = {3{8'h3C}};
    cyc_wait(130);

    // Back-to-back 00 then FF with valid held.
    tx_data  = {3{8'h00}};
    tx_valid = '1;
    cyc_wait(50);
    tx_data  = {3{8'hFF}};
    cyc_wait(130);
    tx_valid = '0;
    cyc_wait(150);

    // Reset during data bit 3, then a clean 55 frame.
    tx_data  = {3{8'hA5}};
    tx_valid = '1;
    cyc_wait(1);
    tx_valid = '0;
    cyc_wait(44);
    rst_n = 1'b0;
    cyc_wait(3);
    rst_n    = 1'b1;
    tx_data  = {3{8'h55}};
    tx_valid = '1;
    cyc_wait(3);
    tx_valid = '0;
    cyc_wait(150);

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < NCFG; k++) begin
        tx_valid[k] = ($urandom_range(0, 3) != 0);
        tx_data[k]  = 8'($urandom);
      end
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        cyc_wait(2);
        rst_n = 1'b1;
      end
      cyc_wait(1);
    end
    tx_valid = '0;
    cyc_wait(150);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter: the transmit-direction counterpart of the receive path. It has an internal baud-tick counter and a valid/ready byte input, and serialises each accepted word as an LSB-first asynchronous frame: start bit, data bits, optional parity, then stop bits. It sits between the system-side producer and the FPGA TX pin, driven directly by the system oscillator clock.

Parameters:
system_clock, 25000000, system oscillator frequency in Hz
tx_baudrate, 9600, line baud rate in bits/s
data_width, 8, data bits per frame (5..9)
parity_mode, 0, 0 = none, 1 = even, 2 = odd
stop_bits, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tx_data  input  data_width  word to send, sampled on accept
tx_valid  input  1  producer has a word
tx_ready  output  1  transmitter can accept a word (registered)
tx  output  1  serial line, idle high (registered)
tx_busy  output  1  frame in progress (registered)
tx_done  output  1  one-cycle pulse at frame completion (registered)

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: tx=1, tx_ready=0, tx_busy=0, tx_done=0, state IDLE, baud counter 0, shift register 0. rst_n low mid-frame aborts the frame: tx goes to 1 immediately, with no partial frame resumed. tx_ready rises on the first clk edge after rst_n deasserts.
- clks_per_bit = system_clock/tx_baudrate, integer truncation; default 2604. It must be ≥ 2; synthesis/elaboration fails otherwise. Baud counter width = $clog2(clks_per_bit).
- Accept: tx_valid and tx_ready are both high at a rising edge. On that edge:
  - tx_data is latched.
  - The parity bit is computed: even = XOR of data; odd = its inverse.
  - tx_ready goes 0, tx_busy goes 1, tx goes 0 (start bit), and the baud counter is cleared.
  - tx_data and tx_valid are ignored while tx_ready=0.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, tx_ready=1. Goes to START on accept.
  - START: tx=0 for clks_per_bit cycles, then DATA.
  - DATA: tx = bit i, i = 0..data_width-1 (LSB first). Each bit lasts clks_per_bit cycles. After the last bit, goes to PARITY if parity_mode≠0, else STOP.
  - PARITY: tx = parity bit for clks_per_bit cycles, then STOP.
  - STOP: tx=1 for stop_bits*clks_per_bit cycles, then IDLE.
- Bit timing: each bit period is exactly clks_per_bit clk cycles. A bit change occurs on the edge where the baud counter equals clks_per_bit-1; the counter then wraps to 0. No drift accumulates across the frame.
- Frame length: N = (1 + data_width + (parity_mode≠0) + stop_bits) * clks_per_bit cycles. On the edge N cycles after the accept edge:
  - the state returns to IDLE;
  - tx_ready goes to 1, tx_busy goes to 0;
  - tx_done is 1 for exactly one cycle.
- Back-to-back: with tx_valid held high, the next accept occurs on the edge after tx_ready rises. The line therefore stays high for exactly one extra clk cycle between frames (no glitch, no truncated stop bit).
- tx_valid high while tx_ready=0 is not an error. The word is simply held by the producer until accepted.
- Invalid parity_mode (3) behaves as none. Invalid stop_bits values other than 2 behave as 1.

Test Plan:
- Reset: hold rst_n=0 with tx_valid=1 → tx=1, tx_ready=0, tx_busy=0, tx_done=0. One edge after release → tx_ready=1, then accept occurs.
- Single frame, system_clock=1000000, tx_baudrate=100000 (10 clks/bit), 8N1, tx_data=8'hA5 → tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit exactly 10 cycles. tx_done pulses 100 cycles after accept; tx_ready low for those 100 cycles.
- Parity/stop: parity_mode=1, stop_bits=2, tx_data=8'h07 → parity bit 1, frame 120 cycles. Repeat with parity_mode=2 → parity bit 0.
- Back-to-back: tx_valid held high, data 8'h00 then 8'hFF → second start bit begins 101 cycles after first accept. No low glitch on tx between frames; tx_done pulses twice.
- Data held during frame: change tx_data mid-frame to 8'h3C → transmitted bits still match the originally latched 8'hA5.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 → tx=1 immediately (asynchronously). After release, a new word 8'h55 transmits as a complete, correctly timed frame.
